// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin framing arbiter in front of the shared serial transmitter
module uart_tx_arbiter #(
    parameter int BUSY_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disk_req,
    input  logic [7:0]  disk_cmd,
    input  logic [15:0] disk_sect,
    input  logic        dbg_req,
    input  logic [31:0] dbg_pc,
    input  logic [31:0] dbg_ir,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        disk_done,
    output logic        dbg_done,
    output logic        active,
    output logic        owner
);

    localparam int WW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [71:0]   frame_q;
    logic [3:0]    count_q;
    logic [WW-1:0] wait_q;
    logic          tx_start_q;
    logic [7:0]    tx_data_q;
    logic          disk_done_q;
    logic          dbg_done_q;
    logic          active_q;
    logic          owner_q;
    logic          grant_dbg_d;

    // On a tie the requester that did not own the last frame wins.
    always_comb begin
        grant_dbg_d = dbg_req && (!disk_req || !owner_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            count_q     <= '0;
            wait_q      <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            disk_done_q <= 1'b0;
            dbg_done_q  <= 1'b0;
            active_q    <= 1'b0;
            owner_q     <= 1'b1;
        end else begin
            tx_start_q  <= 1'b0;
            disk_done_q <= 1'b0;
            dbg_done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!tx_busy && (disk_req || dbg_req)) begin
                        owner_q  <= grant_dbg_d;
                        frame_q  <= grant_dbg_d ? {dbg_ir, dbg_pc, 8'h03}
                                                : {48'd0, disk_sect, disk_cmd};
                        count_q  <= grant_dbg_d ? 4'd9 : 4'd3;
                        active_q <= 1'b1;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= frame_q[7:0];
                    wait_q     <= '0;
                    state_q    <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    // A transmitter that never raises busy is assumed to have taken the byte.
                    if (tx_busy || (wait_q == WW'(BUSY_WAIT - 1))) begin
                        state_q <= S_WAIT_LO;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        count_q <= count_q - 4'd1;
                        if (count_q == 4'd1) begin
                            state_q <= S_DONE;
                        end else begin
                            frame_q <= frame_q >> 8;
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    disk_done_q <= !owner_q;
                    dbg_done_q  <= owner_q;
                    active_q    <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q  <= S_IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign disk_done = disk_done_q;
    assign dbg_done  = dbg_done_q;
    assign active    = active_q;
    assign owner     = owner_q;

endmodule
